decode_stage: RTL and testbench

- Registered RV32I decode pipeline stage between fetch and execute.
- Accepts one 32-bit instruction and its PC per valid/ready beat.
- Produces the decoded control word, the register indices and a sign-extended immediate one cycle later.
- Has a 2-entry output buffer (main + skid), so `in_ready` is a registered signal. Also has a synchronous flush and a saturating illegal-instruction counter.

---
 rtl/decode_stage.sv | 166 ++++++++++++++++
 tb/tb_decode_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the incoming beat, registered into
// a main/skid output buffer so in_ready comes straight from a flop.
module decode_stage #(
  parameter int DATA_WIDTH        = 32,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int ILLEGAL_CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [DATA_WIDTH-1:0]        in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_pc,
  output logic [2:0]                   alu_op,
  output logic [2:0]                   imm_op,
  output logic [DATA_WIDTH-1:0]        imm,
  output logic [REG_ADDR_WIDTH-1:0]    rs1,
  output logic [REG_ADDR_WIDTH-1:0]    rs2,
  output logic [REG_ADDR_WIDTH-1:0]    rd,
  output logic                         reg_write,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic                         branch,
  output logic                         jump,
  output logic                         illegal,
  output logic [ILLEGAL_CNT_WIDTH-1:0] illegal_count
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     pc;
    logic [2:0]                alu_op;
    logic [2:0]                imm_op;
    logic [DATA_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic                      branch;
    logic                      jump;
    logic                      illegal;
  } dec_t;

  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010,
                         IMM_U = 3'b011, IMM_J = 3'b100, IMM_N = 3'b101,
                         INV   = 3'b111;

  dec_t dec, inv_word, main_q, skid_q;
  logic main_vld, skid_vld;
  logic use_rs1, use_rs2, use_rd;
  logic signed [31:0] imm32;
  logic accept, consume;

  always_comb begin
    inv_word        = '0;
    inv_word.alu_op = INV;
    inv_word.imm_op = INV;
  end

  // Opcode decode; fields and immediate are gated afterwards by the use flags.
  always_comb begin
    dec        = inv_word;
    dec.pc     = in_pc;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    use_rd     = 1'b0;
    case (in_instr[6:0])
      7'b0000011: begin dec.alu_op = 3'b000; dec.imm_op = IMM_I; dec.reg_write = 1'b1;
                        dec.mem_read = 1'b1; use_rs1 = 1'b1; use_rd = 1'b1; end
      7'b0100011: begin dec.alu_op = 3'b000; dec.imm_op = IMM_S; dec.mem_write = 1'b1;
                        use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b0010011: begin dec.alu_op = 3'b010; dec.imm_op = IMM_I; dec.reg_write = 1'b1;
                        use_rs1 = 1'b1; use_rd = 1'b1; end
      7'b0110011: begin dec.alu_op = 3'b001; dec.imm_op = IMM_N; dec.reg_write = 1'b1;
                        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; end
      7'b1100011: begin dec.alu_op = 3'b011; dec.imm_op = IMM_B; dec.branch = 1'b1;
                        use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b0110111: begin dec.alu_op = 3'b100; dec.imm_op = IMM_U; dec.reg_write = 1'b1;
                        use_rd = 1'b1; end
      7'b0010111: begin dec.alu_op = 3'b000; dec.imm_op = IMM_U; dec.reg_write = 1'b1;
                        use_rd = 1'b1; end
      7'b1101111: begin dec.alu_op = 3'b000; dec.imm_op = IMM_J; dec.reg_write = 1'b1;
                        dec.jump = 1'b1; use_rd = 1'b1; end
      7'b1100111: begin dec.alu_op = 3'b000; dec.imm_op = IMM_I; dec.reg_write = 1'b1;
                        dec.jump = 1'b1; use_rs1 = 1'b1; use_rd = 1'b1; end
      default:    dec.illegal = 1'b1;
    endcase
    case (dec.imm_op)
      IMM_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      IMM_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      IMM_B:   imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                        in_instr[11:8], 1'b0};
      IMM_U:   imm32 = {in_instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                        in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    dec.imm = DATA_WIDTH'(imm32);
    dec.rs1 = use_rs1 ? REG_ADDR_WIDTH'(in_instr[19:15]) : '0;
    dec.rs2 = use_rs2 ? REG_ADDR_WIDTH'(in_instr[24:20]) : '0;
    dec.rd  = use_rd  ? REG_ADDR_WIDTH'(in_instr[11:7])  : '0;
  end

  assign in_ready = !skid_vld;
  assign accept   = in_valid && in_ready && !flush;
  assign consume  = main_vld && out_ready;

  // Skid is only ever filled while main is stalled, and can't fill again until it
  // has drained into main, so accept and skid->main never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q   <= inv_word;
      skid_q   <= inv_word;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (consume) begin
      if (skid_vld) begin
        main_q   <= skid_q;
        skid_vld <= 1'b0;
      end else if (accept) begin
        main_q   <= dec;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (accept) begin
      if (!main_vld) begin
        main_q   <= dec;
        main_vld <= 1'b1;
      end else begin
        skid_q   <= dec;
        skid_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      illegal_count <= '0;
    else if (accept && dec.illegal && illegal_count != '1)
      illegal_count <= illegal_count + 1'b1;
  end

  assign out_valid = main_vld;
  assign out_pc    = main_q.pc;
  assign alu_op    = main_q.alu_op;
  assign imm_op    = main_q.imm_op;
  assign imm       = main_q.imm;
  assign rs1       = main_q.rs1;
  assign rs2       = main_q.rs2;
  assign rd        = main_q.rd;
  assign reg_write = main_q.reg_write;
  assign mem_read  = main_q.mem_read;
  assign mem_write = main_q.mem_write;
  assign branch    = main_q.branch;
  assign jump      = main_q.jump;
  assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: scoreboard of reference-decoded beats plus directed
// handshake, flush and counter-saturation checks.
module tb_decode_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, imm;
  logic [2:0]  alu_op, imm_op;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_write, mem_read, mem_write, branch, jump, illegal;
  logic [15:0] illegal_count;

  decode_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .ILLEGAL_CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .alu_op(alu_op), .imm_op(imm_op), .imm(imm), .rs1(rs1), .rs2(rs2),
    .rd(rd), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .illegal(illegal), .illegal_count(illegal_count));

  // second instance with a 2-bit counter for saturation
  logic        s_rst, s_in_valid, s_in_ready, s_out_valid;
  logic [31:0] s_out_pc, s_imm;
  logic [2:0]  s_alu_op, s_imm_op;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic        s_reg_write, s_mem_read, s_mem_write, s_branch, s_jump, s_illegal;
  logic [1:0]  s_count;

  decode_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .ILLEGAL_CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(s_rst), .flush(1'b0), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_instr(32'h0000_0000), .in_pc(32'h0), .out_valid(s_out_valid), .out_ready(1'b1),
    .out_pc(s_out_pc), .alu_op(s_alu_op), .imm_op(s_imm_op), .imm(s_imm), .rs1(s_rs1),
    .rs2(s_rs2), .rd(s_rd), .reg_write(s_reg_write), .mem_read(s_mem_read),
    .mem_write(s_mem_write), .branch(s_branch), .jump(s_jump), .illegal(s_illegal),
    .illegal_count(s_count));

  int errors = 0;
  int checks = 0;
  logic [90:0] sb_q[$];

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference decode, layout {pc, alu, immop, imm, rs1, rs2, rd, rw, mr, mw, br, j, ill}
  function automatic logic [90:0] model(input logic [31:0] i, input logic [31:0] pc);
    logic [2:0] a, t; logic [31:0] v; logic [4:0] r1, r2, d; logic [5:0] f;
    r1 = i[19:15]; r2 = i[24:20]; d = i[11:7];
    case (i[6:0])
      7'h03: begin a = 0; t = 0; f = 6'b110000; r2 = 0; v = {{20{i[31]}}, i[31:20]}; end
      7'h23: begin a = 0; t = 1; f = 6'b001000; d = 0; v = {{20{i[31]}}, i[31:25], i[11:7]}; end
      7'h13: begin a = 2; t = 0; f = 6'b100000; r2 = 0; v = {{20{i[31]}}, i[31:20]}; end
      7'h33: begin a = 1; t = 5; f = 6'b100000; v = 0; end
      7'h63: begin a = 3; t = 2; f = 6'b000100; d = 0;
                   v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; end
      7'h37: begin a = 4; t = 3; f = 6'b100000; r1 = 0; r2 = 0; v = {i[31:12], 12'h0}; end
      7'h17: begin a = 0; t = 3; f = 6'b100000; r1 = 0; r2 = 0; v = {i[31:12], 12'h0}; end
      7'h6f: begin a = 0; t = 4; f = 6'b100010; r1 = 0; r2 = 0;
                   v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; end
      7'h67: begin a = 0; t = 0; f = 6'b100010; r2 = 0; v = {{20{i[31]}}, i[31:20]}; end
      default: begin a = 7; t = 7; f = 6'b000001; r1 = 0; r2 = 0; d = 0; v = 0; end
    endcase
    return {pc, a, t, v, r1, r2, d, f};
  endfunction

  // Handshake monitor: inputs are stable from the negedge to the next posedge.
  always @(negedge clk) begin
    if (rst || flush) sb_q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("sb_underflow", sb_q.size(), 1);
        else chk("sb_beat", {out_pc, alu_op, imm_op, imm, rs1, rs2, rd, reg_write,
                             mem_read, mem_write, branch, jump, illegal}, sb_q.pop_front());
      end
      if (in_valid && in_ready) sb_q.push_back(model(in_instr, in_pc));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); acc = in_ready && !flush;
      @(posedge clk); #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", acc, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] cnt0;
    rst = 1; s_rst = 1; flush = 0; in_valid = 0; out_ready = 0; s_in_valid = 0;
    in_instr = 0; in_pc = 0;
    repeat (2) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", illegal_count, 0);
    chk("rst_word", {out_pc, alu_op, imm_op, imm, rs1, rs2, rd, reg_write, mem_read,
                     mem_write, branch, jump, illegal}, {32'h0, 3'b111, 3'b111, 32'h0, 15'h0, 6'h0});
    rst = 0; s_rst = 0; out_ready = 1;

    send(32'h000AAA83, 32'h100);                       // lw x21,0(x21)
    chk("lw_valid", out_valid, 1);
    chk("lw_ctrl", {alu_op, imm_op, mem_read, reg_write, mem_write, illegal}, {3'b000, 3'b000, 4'b1100});
    chk("lw_regs", {rs1, rs2, rd}, {5'd21, 5'd0, 5'd21});
    chk("lw_imm", imm, 0);

    send(32'hFFFFFFFF, 32'h104);
    chk("ill1_word", {alu_op, imm_op, rs1, rs2, rd, reg_write, mem_read, mem_write,
                      branch, jump, illegal}, {3'b111, 3'b111, 15'h0, 6'b000001});
    send(32'h00000000, 32'h108);
    chk("ill2_illegal", {alu_op, imm_op, illegal}, {3'b111, 3'b111, 1'b1});
    chk("ill_count", illegal_count, 2);

    send(32'hFE208EE3, 32'h10C);                       // beq x1,x2,-4
    chk("beq_ctrl", {alu_op, imm_op, branch, reg_write, jump}, {3'b011, 3'b010, 3'b100});
    chk("beq_regs", {rs1, rs2, rd}, {5'd1, 5'd2, 5'd0});
    chk("beq_imm", imm, 32'hFFFFFFFC);

    // a few more opcodes through the scoreboard
    send(32'h123450B7, 32'h110);                       // lui
    send(32'h00C58533, 32'h114);                       // add
    send(32'hFE112E23, 32'h118);                       // sw
    send(32'h800000EF, 32'h11C);                       // jal
    send(32'hFFC08067, 32'h120);                       // jalr
    send(32'h00001297, 32'h124);                       // auipc
    tick();

    // backpressure: main + skid fill, third beat held upstream
    out_ready = 0;
    in_valid = 1; in_instr = 32'h00100093; in_pc = 32'h200; tick();
    in_instr = 32'h00200113; in_pc = 32'h204; tick();
    chk("bp_in_ready_low", in_ready, 0);
    in_instr = 32'h00300193; in_pc = 32'h208; tick();
    chk("bp_hold_pc", {out_valid, out_pc, in_ready}, {1'b1, 32'h200, 1'b0});
    tick();
    chk("bp_hold_pc2", {out_valid, out_pc, rd}, {1'b1, 32'h200, 5'd1});
    out_ready = 1; tick();
    chk("bp_pc_b", {out_valid, out_pc, in_ready}, {1'b1, 32'h204, 1'b1});
    tick();
    chk("bp_pc_c", {out_valid, out_pc}, {1'b1, 32'h208});
    in_valid = 0; tick();
    chk("bp_drained", out_valid, 0);

    // flush with both entries full and a beat offered
    out_ready = 0;
    send(32'h00000013, 32'h300);
    send(32'h00100093, 32'h304);
    cnt0 = illegal_count;
    flush = 1; in_valid = 1; in_instr = 32'hFFFFFFFF; in_pc = 32'h308; tick();
    flush = 0; in_valid = 0;
    chk("fl_state", {out_valid, in_ready}, 2'b01);
    chk("fl_count", illegal_count, cnt0);
    flush = 1; in_valid = 1; tick();                   // offered while in_ready=1
    flush = 0; in_valid = 0;
    chk("fl2_state", {out_valid, illegal_count}, {1'b0, cnt0});
    out_ready = 1; repeat (3) tick();
    chk("fl_no_ghost", out_valid, 0);

    // 2-bit counter saturation
    s_in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("sat_count", s_count, (k < 3) ? k + 1 : 3);
    end
    s_in_valid = 0; s_rst = 1; tick(); s_rst = 0;
    chk("sat_rst", {s_count, s_out_valid, s_in_ready}, {2'd0, 1'b0, 1'b1});

    repeat (2) tick();
    chk("sb_drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
